// File: rtl/mcdt_arbiter.sv
// mcdt_arbiter: selects one slave FIFO by priority (round-robin among equals), pops one
// word with a single-cycle ack, and presents it with its channel id over valid/ready.
module mcdt_arbiter #(
   parameter int NUM_CH = 3,
   parameter int DW     = 32,
   parameter int IDW    = 2
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [NUM_CH-1:0]    slv_en_i,
   input  logic [2*NUM_CH-1:0]  slv_prio_i,
   input  logic [NUM_CH-1:0]    slv_req_i,
   input  logic [NUM_CH-1:0]    slv_val_i,
   input  logic [NUM_CH*DW-1:0] slv_data_i,
   output logic [NUM_CH-1:0]    a2s_ack_o,
   output logic                 arb_val_o,
   output logic [DW-1:0]        arb_data_o,
   output logic [IDW-1:0]       arb_id_o,
   input  logic                 fmt_ready_i,
   output logic                 arb_err_o,
   output logic [1:0]           dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      CAPT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDW-1:0]      r_grant;
   logic [IDW-1:0]      r_last;
   logic [IDW-1:0]      r_id;
   logic [NUM_CH-1:0]   r_ack;
   logic [DW-1:0]       r_data;
   logic                r_val;
   logic                r_err;

   logic [NUM_CH-1:0]   w_elig;
   logic [NUM_CH-1:0]   w_cand;
   logic [NUM_CH-1:0]   w_win_oh;
   logic [NUM_CH-1:0]   w_grant_oh;
   logic [IDW-1:0]      w_win;
   logic [1:0]          w_pmin;
   logic                w_found;
   logic                w_out_free;
   logic                w_grant_en;
   logic                w_capture;
   logic                w_err_set;
   logic                w_val_g;
   logic [DW-1:0]       w_cap_data;

   // Handshake: a word leaves on any rising edge with arb_val_o && fmt_ready_i; that same
   // edge may also launch the next grant, so the output slot counts as free then.
   assign w_out_free = !r_val || fmt_ready_i;

   always_comb begin
      w_elig = slv_req_i & slv_en_i;
      w_pmin = 2'd3;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_elig[c] && (slv_prio_i[2*c +: 2] < w_pmin)) w_pmin = slv_prio_i[2*c +: 2];
      end
      w_cand = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_cand[c] = w_elig[c] && (slv_prio_i[2*c +: 2] == w_pmin);
      end
      // Rotate: indices above the last grant first, then wrap to index 0 upward.
      w_found = 1'b0;
      w_win   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (!w_found && w_cand[c] && (IDW'(c) > r_last)) begin
            w_found = 1'b1;
            w_win   = IDW'(c);
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (!w_found && w_cand[c] && (IDW'(c) <= r_last)) begin
            w_found = 1'b1;
            w_win   = IDW'(c);
         end
      end
      w_win_oh = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_win_oh[c] = (w_win == IDW'(c));
      end
   end

   always_comb begin
      w_cap_data = '0;
      w_val_g    = 1'b0;
      w_grant_oh = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (r_grant == IDW'(c)) begin
            w_cap_data    = slv_data_i[DW*c +: DW];
            w_val_g       = slv_val_i[c];
            w_grant_oh[c] = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_en  = 1'b0;
      w_capture   = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         IDLE: begin
            w_err_set = |slv_val_i;
            if (w_found && w_out_free) begin
               w_grant_en  = 1'b1;
               w_state_nxt = ACK;
            end
         end
         ACK: begin
            w_err_set   = |slv_val_i;
            w_state_nxt = CAPT;
         end
         CAPT: begin
            w_capture   = w_val_g;
            w_err_set   = !w_val_g || (|(slv_val_i & ~w_grant_oh));
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_ack   <= '0;
         r_grant <= '0;
         r_last  <= IDW'(NUM_CH - 1);
         r_val   <= 1'b0;
         r_data  <= '0;
         r_id    <= '0;
         r_err   <= 1'b0;
      end else begin
         r_ack <= '0;
         if (w_grant_en) begin
            r_ack   <= w_win_oh;
            r_grant <= w_win;
            r_last  <= w_win;
         end
         if (r_val && fmt_ready_i) r_val <= 1'b0;
         if (w_capture) begin
            r_val  <= 1'b1;
            r_data <= w_cap_data;
            r_id   <= r_grant;
         end
         if (w_err_set) r_err <= 1'b1;
      end
   end

   assign a2s_ack_o   = r_ack;
   assign arb_val_o   = r_val;
   assign arb_data_o  = r_data;
   assign arb_id_o    = r_id;
   assign arb_err_o   = r_err;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mcdt_arbiter.sv
// tb_mcdt_arbiter: slave FIFO models feed the arbiter; expected (id, data) words come
// from a transaction-level priority/round-robin model.
module tb_mcdt_arbiter;
   localparam int NUM_CH = 3;
   localparam int DW     = 32;
   localparam int IDW    = 2;

   logic                 clk_i = 1'b0;
   logic                 rstn_i = 1'b1;
   logic [NUM_CH-1:0]    slv_en_i = '1;
   logic [2*NUM_CH-1:0]  slv_prio_i = '0;
   logic [NUM_CH-1:0]    slv_req_i = '0;
   logic [NUM_CH-1:0]    slv_val_m = '0;
   logic [NUM_CH-1:0]    inj_val = '0;
   logic [NUM_CH-1:0]    slv_val_i;
   logic [NUM_CH*DW-1:0] slv_data_i = '0;
   logic                 fmt_ready_i = 1'b0;
   logic [NUM_CH-1:0]    a2s_ack_o;
   logic                 arb_val_o;
   logic [DW-1:0]        arb_data_o;
   logic [IDW-1:0]       arb_id_o;
   logic                 arb_err_o;
   logic [1:0]           dbg_state_o;

   int n_cmp = 0;
   int n_err = 0;
   int model_last = NUM_CH - 1;
   logic [DW-1:0]     fifo_q[NUM_CH][$];
   logic [DW-1:0]     model_q[NUM_CH][$];
   logic [IDW+DW-1:0] exp_q[$];
   logic [NUM_CH-1:0] pend = '0;
   logic [DW-1:0]     pend_data[NUM_CH];
   logic              withhold = 1'b0;

   assign slv_val_i = slv_val_m | inj_val;

   always #5 clk_i = ~clk_i;

   mcdt_arbiter #(.NUM_CH(NUM_CH), .DW(DW), .IDW(IDW)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .slv_en_i(slv_en_i), .slv_prio_i(slv_prio_i),
      .slv_req_i(slv_req_i), .slv_val_i(slv_val_i), .slv_data_i(slv_data_i),
      .a2s_ack_o(a2s_ack_o), .arb_val_o(arb_val_o), .arb_data_o(arb_data_o),
      .arb_id_o(arb_id_o), .fmt_ready_i(fmt_ready_i), .arb_err_o(arb_err_o),
      .dbg_state_o(dbg_state_o)
   );

   // Slave FIFOs: an ack seen in one cycle pops a word that is presented with valid in the next.
   always @(negedge clk_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
         slv_val_m[c] = 1'b0;
         if (!rstn_i) pend[c] = 1'b0;
         if (pend[c]) begin
            slv_val_m[c] = !withhold;
            slv_data_i[DW*c +: DW] = pend_data[c];
            pend[c] = 1'b0;
         end
         if (rstn_i && a2s_ack_o[c]) begin
            pend[c] = 1'b1;
            pend_data[c] = '0;
            if (fifo_q[c].size() != 0) pend_data[c] = fifo_q[c].pop_front();
         end
         slv_req_i[c] = (fifo_q[c].size() != 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic load(input int c, input logic [DW-1:0] w);
      fifo_q[c].push_back(w);
      model_q[c].push_back(w);
   endtask

   // Whole-transaction model: lowest priority value wins, ties go to the next index after the last winner.
   function automatic void model_run();
      int pmin;
      int c;
      logic [DW-1:0] w;
      while (1) begin
         pmin = 4;
         for (int i = 0; i < NUM_CH; i++) begin
            if (model_q[i].size() != 0 && slv_en_i[i] && int'(slv_prio_i[2*i +: 2]) < pmin)
               pmin = int'(slv_prio_i[2*i +: 2]);
         end
         if (pmin == 4) break;
         for (int k = 1; k <= NUM_CH; k++) begin
            c = (model_last + k) % NUM_CH;
            if (model_q[c].size() != 0 && slv_en_i[c] && int'(slv_prio_i[2*c +: 2]) == pmin) begin
               w = model_q[c].pop_front();
               exp_q.push_back({IDW'(c), w});
               model_last = c;
               break;
            end
         end
      end
   endfunction

   task automatic apply_reset();
      rstn_i = 1'b0;
      inj_val = '0;
      withhold = 1'b0;
      fmt_ready_i = 1'b0;
      slv_en_i = '1;
      slv_prio_i = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         fifo_q[c].delete();
         model_q[c].delete();
      end
      exp_q.delete();
      model_last = NUM_CH - 1;
      repeat (2) @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      #1 rstn_i = 1'b0;
      #1;
      n_cmp++;
      if ({a2s_ack_o, arb_val_o, arb_data_o, arb_id_o, arb_err_o, dbg_state_o} !== '0) begin
         n_err++;
         $display("FAIL reset_async: got ack=%b val=%b data=%h id=%0d err=%b st=%0d, expected all 0",
                  a2s_ack_o, arb_val_o, arb_data_o, arb_id_o, arb_err_o, dbg_state_o);
      end
      apply_reset();
      repeat (3) @(negedge clk_i);
      n_cmp++;
      if ({a2s_ack_o, arb_val_o, arb_err_o, dbg_state_o} !== '0) begin
         n_err++;
         $display("FAIL reset_idle: got ack=%b val=%b err=%b st=%0d, expected all 0",
                  a2s_ack_o, arb_val_o, arb_err_o, dbg_state_o);
      end
   endtask

   task automatic test_single();
      int ack_cyc[$];
      logic [IDW+DW-1:0] exp_w;
      apply_reset();
      fmt_ready_i = 1'b1;
      load(1, 32'hA1);
      load(1, 32'hA2);
      exp_q.push_back({2'd1, 32'hA1});
      exp_q.push_back({2'd1, 32'hA2});
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk_i);
         if (a2s_ack_o != '0) begin
            ack_cyc.push_back(cyc);
            n_cmp++;
            if (a2s_ack_o !== 3'b010) begin
               n_err++;
               $display("FAIL single_ack: got %b, expected 010", a2s_ack_o);
            end
         end
         if (arb_val_o && fmt_ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL single_extra: got id=%0d data=%h, expected no word", arb_id_o, arb_data_o);
            end else begin
               exp_w = exp_q.pop_front();
               if ({arb_id_o, arb_data_o} !== exp_w) begin
                  n_err++;
                  $display("FAIL single_word: got id=%0d data=%h, expected id=%0d data=%h",
                           arb_id_o, arb_data_o, exp_w[DW +: IDW], exp_w[DW-1:0]);
               end
            end
         end
      end
      n_cmp++;
      if (ack_cyc.size() != 2) begin
         n_err++;
         $display("FAIL single_ack_count: got %0d, expected 2", ack_cyc.size());
      end else begin
         n_cmp++;
         if (ack_cyc[1] - ack_cyc[0] != 3) begin
            n_err++;
            $display("FAIL single_ack_gap: got %0d, expected 3", ack_cyc[1] - ack_cyc[0]);
         end
      end
      n_cmp++;
      if (exp_q.size() != 0 || arb_err_o !== 1'b0) begin
         n_err++;
         $display("FAIL single_end: got pending=%0d err=%b, expected 0 and 0", exp_q.size(), arb_err_o);
      end
   endtask

   task automatic test_round_robin();
      logic [IDW+DW-1:0] exp_w;
      apply_reset();
      fmt_ready_i = 1'b1;
      slv_prio_i = 6'b01_01_01;
      for (int n = 0; n < 2; n++)
         for (int c = 0; c < NUM_CH; c++) load(c, $urandom);
      model_run();
      for (int cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) begin
         @(negedge clk_i);
         if (arb_val_o && fmt_ready_i) begin
            n_cmp++;
            exp_w = exp_q.pop_front();
            if ({arb_id_o, arb_data_o} !== exp_w) begin
               n_err++;
               $display("FAIL rr_word: got id=%0d data=%h, expected id=%0d data=%h",
                        arb_id_o, arb_data_o, exp_w[DW +: IDW], exp_w[DW-1:0]);
            end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL rr_drain: got %0d words pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_priority();
      logic [IDW+DW-1:0] exp_w;
      logic saw_ack2;
      apply_reset();
      fmt_ready_i = 1'b1;
      slv_prio_i = 6'b00_00_11;
      for (int n = 0; n < 3; n++) begin
         load(2, $urandom);
         load(0, $urandom);
      end
      model_run();
      for (int pass = 0; pass < 2; pass++) begin
         saw_ack2 = 1'b0;
         for (int cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) begin
            @(negedge clk_i);
            if (a2s_ack_o[2]) saw_ack2 = 1'b1;
            if (arb_val_o && fmt_ready_i) begin
               n_cmp++;
               exp_w = exp_q.pop_front();
               if ({arb_id_o, arb_data_o} !== exp_w) begin
                  n_err++;
                  $display("FAIL prio_word: got id=%0d data=%h, expected id=%0d data=%h",
                           arb_id_o, arb_data_o, exp_w[DW +: IDW], exp_w[DW-1:0]);
               end
            end
         end
         n_cmp++;
         if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL prio_drain: got %0d words pending, expected 0", exp_q.size());
         end
         if (pass == 0) begin
            apply_reset();
            fmt_ready_i = 1'b1;
            slv_prio_i = 6'b00_00_11;
            slv_en_i = 3'b011;
            for (int n = 0; n < 3; n++) load(2, $urandom);
            for (int n = 0; n < 2; n++) load(0, $urandom);
            model_run();
         end
      end
      repeat (6) @(negedge clk_i);
      n_cmp++;
      if (saw_ack2 || fifo_q[2].size() != 3) begin
         n_err++;
         $display("FAIL prio_disabled: got ack2_seen=%b ch2_left=%0d, expected 0 and 3", saw_ack2, fifo_q[2].size());
      end
   endtask

   task automatic test_backpressure();
      logic got;
      apply_reset();
      load(0, 32'h55);
      load(0, 32'h66);
      got = 1'b0;
      for (int cyc = 0; cyc < 20 && !got; cyc++) begin
         @(negedge clk_i);
         got = arb_val_o;
      end
      n_cmp++;
      if (!got || arb_data_o !== 32'h55 || arb_id_o !== 2'd0) begin
         n_err++;
         $display("FAIL bp_first: got val=%b data=%h id=%0d, expected 1 55 0", got, arb_data_o, arb_id_o);
      end
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk_i);
         n_cmp++;
         if ({arb_val_o, arb_data_o, arb_id_o, a2s_ack_o} !== {1'b1, 32'h55, 2'd0, 3'b000}) begin
            n_err++;
            $display("FAIL bp_hold: got val=%b data=%h id=%0d ack=%b, expected 1 55 0 000",
                     arb_val_o, arb_data_o, arb_id_o, a2s_ack_o);
         end
      end
      fmt_ready_i = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if (a2s_ack_o !== 3'b001 || arb_val_o !== 1'b0) begin
         n_err++;
         $display("FAIL bp_release: got ack=%b val=%b, expected 001 0", a2s_ack_o, arb_val_o);
      end
      repeat (2) @(negedge clk_i);
      n_cmp++;
      if ({arb_val_o, arb_data_o, arb_id_o} !== {1'b1, 32'h66, 2'd0}) begin
         n_err++;
         $display("FAIL bp_second: got val=%b data=%h id=%0d, expected 1 66 0", arb_val_o, arb_data_o, arb_id_o);
      end
   endtask

   task automatic test_protocol_error();
      logic saw_val, saw_ack;
      apply_reset();
      n_cmp++;
      if (arb_err_o !== 1'b0) begin
         n_err++;
         $display("FAIL err_clear: got %b, expected 0", arb_err_o);
      end
      inj_val = 3'b010;
      @(negedge clk_i);
      inj_val = '0;
      n_cmp++;
      if (arb_err_o !== 1'b1) begin
         n_err++;
         $display("FAIL err_idle_val: got %b, expected 1", arb_err_o);
      end
      repeat (5) @(negedge clk_i);
      n_cmp++;
      if (arb_err_o !== 1'b1) begin
         n_err++;
         $display("FAIL err_sticky: got %b, expected 1", arb_err_o);
      end
      apply_reset();
      withhold = 1'b1;
      fmt_ready_i = 1'b1;
      load(2, 32'h77);
      saw_val = 1'b0;
      saw_ack = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk_i);
         if (arb_val_o) saw_val = 1'b1;
         if (a2s_ack_o[2]) saw_ack = 1'b1;
      end
      n_cmp++;
      if (arb_err_o !== 1'b1 || saw_val || !saw_ack) begin
         n_err++;
         $display("FAIL err_missing_val: got err=%b val_seen=%b ack_seen=%b, expected 1 0 1",
                  arb_err_o, saw_val, saw_ack);
      end
   endtask

   task automatic test_async_reset();
      logic got;
      logic [IDW+DW-1:0] exp_w;
      apply_reset();
      fmt_ready_i = 1'b1;
      inj_val = 3'b100;
      @(negedge clk_i);
      inj_val = '0;
      n_cmp++;
      if (arb_err_o !== 1'b1) begin
         n_err++;
         $display("FAIL async_pre_err: got %b, expected 1", arb_err_o);
      end
      load(0, 32'h10);
      load(1, 32'h11);
      got = 1'b0;
      for (int cyc = 0; cyc < 20 && !got; cyc++) begin
         @(negedge clk_i);
         got = a2s_ack_o[0];
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL async_wait_ack: got no ack[0], expected ack[0] within 20 cycles");
      end
      #1 rstn_i = 1'b0;
      #1;
      n_cmp++;
      if ({a2s_ack_o, arb_val_o, arb_err_o} !== '0) begin
         n_err++;
         $display("FAIL async_drop: got ack=%b val=%b err=%b, expected 000 0 0", a2s_ack_o, arb_val_o, arb_err_o);
      end
      apply_reset();
      fmt_ready_i = 1'b1;
      for (int c = NUM_CH - 1; c >= 0; c--) load(c, 32'hC0 + c);
      model_run();
      for (int cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) begin
         @(negedge clk_i);
         if (arb_val_o && fmt_ready_i) begin
            n_cmp++;
            exp_w = exp_q.pop_front();
            if ({arb_id_o, arb_data_o} !== exp_w) begin
               n_err++;
               $display("FAIL async_resume: got id=%0d data=%h, expected id=%0d data=%h",
                        arb_id_o, arb_data_o, exp_w[DW +: IDW], exp_w[DW-1:0]);
            end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0 || arb_err_o !== 1'b0) begin
         n_err++;
         $display("FAIL async_end: got pending=%0d err=%b, expected 0 0", exp_q.size(), arb_err_o);
      end
   endtask

   task automatic test_random();
      logic [IDW+DW-1:0] exp_w;
      logic [NUM_CH-1:0] prev_ack;
      logic bad;
      for (int r = 0; r < 6; r++) begin
         apply_reset();
         for (int c = 0; c < NUM_CH; c++) slv_prio_i[2*c +: 2] = 2'($urandom_range(0, 3));
         slv_en_i = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
         for (int c = 0; c < NUM_CH; c++) begin
            int n;
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) load(c, $urandom);
         end
         model_run();
         bad = 1'b0;
         prev_ack = '0;
         for (int cyc = 0; cyc < 600 && exp_q.size() != 0; cyc++) begin
            @(negedge clk_i);
            fmt_ready_i = ($urandom_range(0, 3) != 0);
            if ($countones(a2s_ack_o) > 1 || (a2s_ack_o & ~slv_en_i) != '0 ||
                (prev_ack != '0 && a2s_ack_o != '0)) bad = 1'b1;
            prev_ack = a2s_ack_o;
            if (arb_val_o && fmt_ready_i) begin
               n_cmp++;
               exp_w = exp_q.pop_front();
               if ({arb_id_o, arb_data_o} !== exp_w) begin
                  n_err++;
                  $display("FAIL rand_word r%0d: got id=%0d data=%h, expected id=%0d data=%h",
                           r, arb_id_o, arb_data_o, exp_w[DW +: IDW], exp_w[DW-1:0]);
               end
            end
         end
         n_cmp++;
         if (bad || exp_q.size() != 0 || arb_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL rand_end r%0d: got ack_bad=%b pending=%0d err=%b, expected 0 0 0",
                     r, bad, exp_q.size(), arb_err_o);
         end
         for (int c = 0; c < NUM_CH; c++) begin
            n_cmp++;
            if (fifo_q[c].size() != model_q[c].size()) begin
               n_err++;
               $display("FAIL rand_left r%0d ch%0d: got %0d words left, expected %0d",
                        r, c, fifo_q[c].size(), model_q[c].size());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_priority();
      test_backpressure();
      test_protocol_error();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
